// File: rtl/ecdsa_engine_ctrl_if.sv
// Job/result and core-operand signal bundle for the ECDSA engine controller.
// The slave modport is the controller's view; master is the host-plus-cores side.
interface ecdsa_engine_ctrl_if #(
  parameter int WIDTH     = 256,
  parameter int MSG_WIDTH = 12
);
  // host job request
  logic                 start;
  logic                 mode;
  logic [MSG_WIDTH-1:0] message;
  logic [WIDTH-1:0]     priv_key;
  logic [WIDTH-1:0]     pub_x;
  logic [WIDTH-1:0]     pub_y;
  logic [WIDTH-1:0]     sig_r_in;
  logic [WIDTH-1:0]     sig_s_in;

  // host status / results
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     sig_r;
  logic [WIDTH-1:0]     sig_s;
  logic                 verify_ok;
  logic                 error;

  // operands and launch pulses to the cores
  logic [MSG_WIDTH-1:0] core_message;
  logic [WIDTH-1:0]     core_key;
  logic [WIDTH-1:0]     core_pub_x;
  logic [WIDTH-1:0]     core_pub_y;
  logic [WIDTH-1:0]     core_r;
  logic [WIDTH-1:0]     core_s;
  logic                 sign_start;
  logic                 ver_start;

  // core completion
  logic                 sign_done;
  logic                 ver_done;
  logic [WIDTH-1:0]     sign_r;
  logic [WIDTH-1:0]     sign_s;
  logic                 ver_ok;

  modport slave (
    input  start, mode, message, priv_key, pub_x, pub_y, sig_r_in, sig_s_in,
    input  sign_done, ver_done, sign_r, sign_s, ver_ok,
    output busy, done, sig_r, sig_s, verify_ok, error,
    output core_message, core_key, core_pub_x, core_pub_y, core_r, core_s,
    output sign_start, ver_start
  );

  modport master (
    output start, mode, message, priv_key, pub_x, pub_y, sig_r_in, sig_s_in,
    output sign_done, ver_done, sign_r, sign_s, ver_ok,
    input  busy, done, sig_r, sig_s, verify_ok, error,
    input  core_message, core_key, core_pub_x, core_pub_y, core_r, core_s,
    input  sign_start, ver_start
  );
endinterface

// File: rtl/ecdsa_engine_ctrl.sv
// ECDSA job sequencer: captures operands, launches the sign or verify core, collects its result.
// Start-to-done 3 cycles + core latency; start is ignored while busy (no queuing), held start re-launches after FINISH.
// Define ECDSA_ENGINE_CTRL_WATCHDOG_EN to abort a core that runs TIMEOUT_CYCLES without done (sets error).
module ecdsa_engine_ctrl #(
  parameter int WIDTH          = 256,
  parameter int MSG_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                clk,
  input logic                rst_n,
  ecdsa_engine_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN_SIGN,
    RUN_VERIFY,
    FINISH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 mode_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sign_start_q;
  logic                 ver_start_q;
  logic                 verify_ok_q;
  logic [WIDTH-1:0]     sig_r_q;
  logic [WIDTH-1:0]     sig_s_q;
  logic [MSG_WIDTH-1:0] core_message_q;
  logic [WIDTH-1:0]     core_key_q;
  logic [WIDTH-1:0]     core_pub_x_q;
  logic [WIDTH-1:0]     core_pub_y_q;
  logic [WIDTH-1:0]     core_r_q;
  logic [WIDTH-1:0]     core_s_q;

  logic accept;
  logic latch_sign;
  logic latch_ver;
  logic timeout;
  logic busy_nxt;
  logic done_nxt;
  logic sign_start_nxt;
  logic ver_start_nxt;

`ifdef ECDSA_ENGINE_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            error_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == LAUNCH) begin
      wd_cnt <= '0;
    end else if (state == RUN_SIGN || state == RUN_VERIFY) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Fires on the last permitted RUN cycle, so exactly TIMEOUT_CYCLES RUN cycles elapse.
  assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (latch_sign || latch_ver) begin
      error_q <= 1'b0;
    end else if ((state == RUN_SIGN || state == RUN_VERIFY) && state_nxt == FINISH) begin
      error_q <= 1'b1;
    end
  end

  assign bus.error = error_q;
`else
  // The timeout only has meaning when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
  assign bus.error      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    latch_sign = 1'b0;
    latch_ver  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = mode_q ? RUN_VERIFY : RUN_SIGN;
      end
      RUN_SIGN: begin
        // A real completion on the timeout cycle still counts as success.
        if (bus.sign_done) begin
          latch_sign = 1'b1;
          state_nxt  = FINISH;
        end else if (timeout) begin
          state_nxt = FINISH;
        end
      end
      RUN_VERIFY: begin
        if (bus.ver_done) begin
          latch_ver = 1'b1;
          state_nxt = FINISH;
        end else if (timeout) begin
          state_nxt = FINISH;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt       = (state_nxt == LAUNCH) || (state_nxt == RUN_SIGN) || (state_nxt == RUN_VERIFY);
    done_nxt       = (state_nxt == FINISH);
    sign_start_nxt = accept && !bus.mode;
    ver_start_nxt  = accept && bus.mode;
  end

  // Status outputs are registered copies of the next-state decode so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sign_start_q <= 1'b0;
      ver_start_q  <= 1'b0;
    end else begin
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      sign_start_q <= sign_start_nxt;
      ver_start_q  <= ver_start_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q         <= 1'b0;
      core_message_q <= '0;
      core_key_q     <= '0;
      core_pub_x_q   <= '0;
      core_pub_y_q   <= '0;
      core_r_q       <= '0;
      core_s_q       <= '0;
    end else if (accept) begin
      mode_q         <= bus.mode;
      core_message_q <= bus.message;
      core_key_q     <= bus.priv_key;
      core_pub_x_q   <= bus.pub_x;
      core_pub_y_q   <= bus.pub_y;
      core_r_q       <= bus.sig_r_in;
      core_s_q       <= bus.sig_s_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_r_q     <= '0;
      sig_s_q     <= '0;
      verify_ok_q <= 1'b0;
    end else begin
      if (latch_sign) begin
        sig_r_q <= bus.sign_r;
        sig_s_q <= bus.sign_s;
      end
      if (latch_ver) begin
        verify_ok_q <= bus.ver_ok;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sign_start   = sign_start_q;
  assign bus.ver_start    = ver_start_q;
  assign bus.verify_ok    = verify_ok_q;
  assign bus.sig_r        = sig_r_q;
  assign bus.sig_s        = sig_s_q;
  assign bus.core_message = core_message_q;
  assign bus.core_key     = core_key_q;
  assign bus.core_pub_x   = core_pub_x_q;
  assign bus.core_pub_y   = core_pub_y_q;
  assign bus.core_r       = core_r_q;
  assign bus.core_s       = core_s_q;

endmodule

// File: tb/tb_ecdsa_engine_ctrl.sv
// Bench for ecdsa_engine_ctrl: stub sign/verify cores, directed jobs, queue scoreboard checked on done.
module tb_ecdsa_engine_ctrl;
  localparam int W        = 256;
  localparam int MW       = 12;
  localparam int TO       = 16;
  localparam int LAT_SIGN = 10;
  localparam int LAT_VER  = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ecdsa_engine_ctrl_if #(.WIDTH(W), .MSG_WIDTH(MW)) bus ();

  ecdsa_engine_ctrl #(.WIDTH(W), .MSG_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stub cores: done is high for one cycle, lat edges after the edge that saw the start pulse
  int         sign_cnt = 0;
  int         ver_cnt  = 0;
  bit         sign_hang = 1'b0;
  logic       inj_sign_done = 1'b0;
  logic       inj_ver_done  = 1'b0;
  logic [W-1:0] stub_r = '0;
  logic [W-1:0] stub_s = '0;
  logic       stub_ok = 1'b0;

  always @(posedge clk) begin
    if (bus.sign_start) sign_cnt <= 1;
    else if (sign_cnt == LAT_SIGN + 1) sign_cnt <= 0;
    else if (sign_cnt != 0) sign_cnt <= sign_cnt + 1;
    if (bus.ver_start) ver_cnt <= 1;
    else if (ver_cnt == LAT_VER + 1) ver_cnt <= 0;
    else if (ver_cnt != 0) ver_cnt <= ver_cnt + 1;
  end

  assign bus.sign_done = ((sign_cnt == LAT_SIGN + 1) && !sign_hang) | inj_sign_done;
  assign bus.ver_done  = (ver_cnt == LAT_VER + 1) | inj_ver_done;
  assign bus.sign_r    = stub_r;
  assign bus.sign_s    = stub_s;
  assign bus.ver_ok    = stub_ok;

  typedef struct {
    logic [W-1:0]  r;
    logic [W-1:0]  s;
    logic          ok;
    logic          err;
    logic [MW-1:0] msg;
    int            lat;
    int            nsign;
    int            nver;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   done_cycs[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   done_count = 0;
  int   n_sign = 0;
  int   n_ver = 0;
  logic prev_busy = 1'b0;

  function automatic exp_t mk(input logic [W-1:0] r, input logic [W-1:0] s, input logic ok,
                              input logic err, input logic [MW-1:0] msg, input int lat,
                              input int nsign, input int nver);
    exp_t e;
    e.r = r; e.s = s; e.ok = ok; e.err = err; e.msg = msg;
    e.lat = lat; e.nsign = nsign; e.nver = nver;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every done pulse pops one expected job
  always @(negedge clk) begin
    if (!rst_n) begin
      n_sign = 0;
      n_ver  = 0;
    end else begin
      if (bus.busy && !prev_busy) acc_cyc = cyc;
      if (bus.sign_start) n_sign++;
      if (bus.ver_start) n_ver++;
      if (bus.done) begin
        done_count++;
        done_cycs.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cycle=%0d actual=1 required=0", cyc);
        end else begin
          cur = sb.pop_front();
          chk("sig_r", bus.sig_r, cur.r);
          chk("sig_s", bus.sig_s, cur.s);
          chki("verify_ok", int'(bus.verify_ok), int'(cur.ok));
          chki("error", int'(bus.error), int'(cur.err));
          chki("busy_at_done", int'(bus.busy), 0);
          chki("core_message", int'(bus.core_message), int'(cur.msg));
          chki("latency", cyc - acc_cyc + 1, cur.lat);
          chki("sign_start_pulses", n_sign, cur.nsign);
          chki("ver_start_pulses", n_ver, cur.nver);
        end
        n_sign = 0;
        n_ver  = 0;
      end
    end
    prev_busy = bus.busy;
  end

  task automatic set_ops(input logic m, input logic [MW-1:0] msg);
    bus.mode     = m;
    bus.message  = msg;
    bus.priv_key = W'(msg) + W'(1);
    bus.pub_x    = W'(msg) + W'(2);
    bus.pub_y    = W'(msg) + W'(3);
    bus.sig_r_in = W'(msg) + W'(4);
    bus.sig_s_in = W'(msg) + W'(5);
  endtask

  task automatic launch(input logic m, input logic [MW-1:0] msg);
    set_ops(m, msg);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int n_before, input int budget, input string name);
    int k = 0;
    while (done_count == n_before && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done_count == n_before) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_done required=done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_zero(input string tag);
    chki($sformatf("%s_busy", tag), int'(bus.busy), 0);
    chki($sformatf("%s_done", tag), int'(bus.done), 0);
    chki($sformatf("%s_sign_start", tag), int'(bus.sign_start), 0);
    chki($sformatf("%s_ver_start", tag), int'(bus.ver_start), 0);
    chki($sformatf("%s_error", tag), int'(bus.error), 0);
    chki($sformatf("%s_verify_ok", tag), int'(bus.verify_ok), 0);
    chk($sformatf("%s_sig_r", tag), bus.sig_r, '0);
    chk($sformatf("%s_sig_s", tag), bus.sig_s, '0);
    chki($sformatf("%s_core_message", tag), int'(bus.core_message), 0);
    chk($sformatf("%s_core_key", tag), bus.core_key, '0);
    chk($sformatf("%s_core_pub_x", tag), bus.core_pub_x, '0);
    chk($sformatf("%s_core_r", tag), bus.core_r, '0);
  endtask

  initial begin
    int n0;
    bus.start = 1'b0;
    set_ops(1'b0, '0);

    repeat (3) @(negedge clk);
    check_zero("reset");

    // sign job presented on the very first edge after reset release
    sb.push_back(mk(W'('h1234), W'('h5678), 1'b0, 1'b0, 12'hABC, 13, 1, 0));
    stub_r = W'('h1234);
    stub_s = W'('h5678);
    n0 = done_count;
    set_ops(1'b0, 12'hABC);
    bus.start = 1'b1;
    rst_n     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chki("first_start_busy", int'(bus.busy), 1);
    chk("core_key_captured", bus.core_key, W'(12'hABC) + W'(1));
    // second start with a new message while the sign core runs
    repeat (3) @(negedge clk);
    set_ops(1'b0, 12'h555);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chki("busy_protect_msg", int'(bus.core_message), 'hABC);
    wait_done(n0, 40, "sign_job");

    // stray ver_done while idle must not produce a done
    @(negedge clk);
    inj_ver_done = 1'b1;
    @(negedge clk);
    inj_ver_done = 1'b0;
    repeat (3) @(negedge clk);

    // verify job; an idle-core sign_done mid-run must be ignored
    sb.push_back(mk(W'('h1234), W'('h5678), 1'b1, 1'b0, 12'h0C3, 8, 0, 1));
    stub_r  = W'('hDEAD);
    stub_s  = W'('hBEEF);
    stub_ok = 1'b1;
    n0 = done_count;
    launch(1'b1, 12'h0C3);
    @(negedge clk);
    inj_sign_done = 1'b1;
    @(negedge clk);
    inj_sign_done = 1'b0;
    wait_done(n0, 40, "verify_job");
    @(negedge clk);

    // verify job that fails
    sb.push_back(mk(W'('h1234), W'('h5678), 1'b0, 1'b0, 12'h0D4, 8, 0, 1));
    stub_ok = 1'b0;
    n0 = done_count;
    launch(1'b1, 12'h0D4);
    wait_done(n0, 40, "verify_fail_job");
    @(negedge clk);

    // back-to-back with start held: sign then verify
    sb.push_back(mk(W'('hAAAA), W'('hBBBB), 1'b0, 1'b0, 12'h0A1, 13, 1, 0));
    sb.push_back(mk(W'('hAAAA), W'('hBBBB), 1'b1, 1'b0, 12'h0B2, 8, 0, 1));
    stub_r  = W'('hAAAA);
    stub_s  = W'('hBBBB);
    stub_ok = 1'b1;
    n0 = done_count;
    set_ops(1'b0, 12'h0A1);
    bus.start = 1'b1;
    @(negedge clk);
    set_ops(1'b1, 12'h0B2);
    wait_done(n0, 40, "b2b_first");
    n0 = done_count;
    begin
      int k = 0;
      while (!bus.busy && k < 10) begin
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    wait_done(n0, 40, "b2b_second");
    if (done_cycs.size() >= 2)
      chki("b2b_spacing", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], 1 + 3 + LAT_VER);
    @(negedge clk);

    // hung sign core
    sign_hang = 1'b1;
    n0 = done_count;
`ifdef ECDSA_ENGINE_CTRL_WATCHDOG_EN
    sb.push_back(mk(W'('hAAAA), W'('hBBBB), 1'b1, 1'b1, 12'h0E5, TO + 2, 1, 0));
    launch(1'b0, 12'h0E5);
    wait_done(n0, 60, "watchdog_job");
    @(negedge clk);
`else
    launch(1'b0, 12'h0E5);
    repeat (100) @(negedge clk);
    chki("hang_busy", int'(bus.busy), 1);
    chki("hang_no_done", done_count, n0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`endif
    sign_hang = 1'b0;

    // successful sign after the hang clears error
    stub_r = W'('h77);
    stub_s = W'('h88);
`ifdef ECDSA_ENGINE_CTRL_WATCHDOG_EN
    sb.push_back(mk(W'('h77), W'('h88), 1'b1, 1'b0, 12'h0F6, 13, 1, 0));
`else
    sb.push_back(mk(W'('h77), W'('h88), 1'b0, 1'b0, 12'h0F6, 13, 1, 0));
`endif
    n0 = done_count;
    launch(1'b0, 12'h0F6);
    wait_done(n0, 40, "sign_after_hang");
    @(negedge clk);

    // reset during RUN_VERIFY; the stub's late ver_done must be ignored
    stub_ok = 1'b1;
    n0 = done_count;
    launch(1'b1, 12'h123);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chki("late_ver_done_ignored", done_count, n0);
    chki("idle_after_reset_busy", int'(bus.busy), 0);

    chki("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
